// File: rtl/audio_pkg.sv
// Shared definitions for the audio output path: ramp FSM encoding and gain constants.
package audio_pkg;

  // Soft-mute ramp states, fixed 2-bit encoding.
  typedef enum logic [1:0] {
    MUTED     = 2'd0,
    RAMP_UP   = 2'd1,
    PLAY      = 2'd2,
    RAMP_DOWN = 2'd3
  } ramp_state_t;

  // Gain is 0..256, where 256 is unity.
  localparam int            GAIN_W   = 9;
  localparam logic [GAIN_W-1:0] GAIN_ONE = 9'd256;

endpackage

// File: rtl/audio_sdm_core.sv
// First-order sigma-delta modulator: the carry out of an accumulator is the
// pulse-density bit, so ones density equals lvl / 2^DW.
module audio_sdm_core #(
  parameter int DW = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] lvl,
  output logic          dout
);

  logic [DW-1:0] acc_r;
  logic [DW:0]   sum;

  assign sum = {1'b0, acc_r} + {1'b0, lvl};

  // Accumulate the level and register the carry as the output bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= '0;
      dout  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, regardless of statement order.
      acc_r <= sum[DW-1:0];
      dout  <= sum[DW];
    end
  end

endmodule

// File: rtl/audio_sigma_delta_dac.sv
// One audio DAC channel: sample latch, soft-mute gain ramp, gain multiply and
// a first-order sigma-delta modulator driving a 1-bit pin.
module audio_sigma_delta_dac
  import audio_pkg::*;
#(
  parameter int AUDIO_DW = 13,
  parameter int RAMP_DIV = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [AUDIO_DW-1:0] din,
  input  logic                din_valid,
  input  logic                mute,
  output logic                dout,
  output logic                muted
);

  localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int MW = AUDIO_DW + GAIN_W;

  logic [AUDIO_DW-1:0] samp_r;
  logic [AUDIO_DW-1:0] lvl_r;
  logic [PW-1:0]       presc_r;
  logic                tick;
  ramp_state_t         state_r, state_nxt;
  logic [GAIN_W-1:0]   gain_r, gain_nxt;
  logic [MW-1:0]       prod;

  // Capture a new sample only on the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) samp_r <= '0;
    else if (din_valid) samp_r <= din;
  end

  // Free-running gain-step prescaler; never restarted by the FSM.
  assign tick = (presc_r == PW'(RAMP_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    presc_r <= '0;
    else if (tick) presc_r <= '0;
    else           presc_r <= presc_r + 1'b1;
  end

  // Ramp FSM next state: a mute reversal always beats a coincident tick.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch
    // is inferred.
    state_nxt = state_r;
    gain_nxt  = gain_r;
    unique case (state_r)
      MUTED: begin
        gain_nxt = '0;
        if (!mute) state_nxt = RAMP_UP;
      end
      RAMP_UP: begin
        if (mute) begin
          state_nxt = RAMP_DOWN;
        end else if (tick) begin
          gain_nxt = gain_r + 1'b1;
          if (gain_r + 1'b1 == GAIN_ONE) state_nxt = PLAY;
        end
      end
      PLAY: begin
        gain_nxt = GAIN_ONE;
        if (mute) state_nxt = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (!mute) begin
          state_nxt = RAMP_UP;
        end else if (tick) begin
          gain_nxt = gain_r - 1'b1;
          if (gain_r == GAIN_W'(1)) state_nxt = MUTED;
        end
      end
      default: begin
        state_nxt = MUTED;
        gain_nxt  = '0;
      end
    endcase
  end

  // Ramp FSM state, gain and the registered muted flag.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: reset is asynchronous so the pin goes silent immediately, even
    // mid-ramp and without a running clock.
    if (!rst_n) begin
      state_r <= MUTED;
      gain_r  <= '0;
      muted   <= 1'b1;
    end else begin
      state_r <= state_nxt;
      gain_r  <= gain_nxt;
      muted   <= (state_nxt == MUTED);
    end
  end

  // Full-width product; gain <= 256 guarantees the shifted result fits.
  assign prod = MW'(samp_r) * MW'(gain_r);

  // Register the scaled level feeding the modulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lvl_r <= '0;
    else        lvl_r <= AUDIO_DW'(prod >> 8);
  end

  audio_sdm_core #(
    .DW (AUDIO_DW)
  ) u_sdm (
    .clk   (clk),
    .rst_n (rst_n),
    .lvl   (lvl_r),
    .dout  (dout)
  );

endmodule

// File: tb/tb_audio_sigma_delta_dac.sv
// Directed bench for one DAC channel with a short gain-step period.
module tb_audio_sigma_delta_dac;
  import audio_pkg::*;

  localparam int DW = 13;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          mute;
  logic          dout;
  logic          muted;

  int checks   = 0;
  int failures = 0;

  audio_sigma_delta_dac #(
    .AUDIO_DW (DW),
    .RAMP_DIV (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .mute      (mute),
    .dout      (dout),
    .muted     (muted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int v);
    din       = DW'(v);
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
  endtask

  // Count ones over one full accumulator period.
  task automatic count_ones(output int n);
    n = 0;
    for (int i = 0; i < 8192; i++) begin
      step();
      if (dout === 1'b1) n++;
    end
  endtask

  task automatic density(input int v, output int n);
    strobe(v);
    repeat (3) step();
    count_ones(n);
  endtask

  task automatic wait_gain(input string tag, input int target, input int budget);
    int n = 0;
    while (int'(dut.gain_r) != target && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(dut.gain_r), 32'(target));
  endtask

  // Alternating mute every clock makes every cycle a reversal, freezing g.
  task automatic hold_step();
    step();
    mute = ~mute;
  endtask

  initial begin
    int  n, cyc, prev, g, last_step;
    bit  ok, mono, spacing, reached;

    rst_n = 1'b0; mute = 1'b1; din = '0; din_valid = 1'b0;
    repeat (3) step();
    check("reset_dout",  32'(dout),  32'd0);
    check("reset_muted", 32'(muted), 32'd1);
    check("reset_gain",  32'(dut.gain_r), 32'd0);
    rst_n = 1'b1;
    step();

    // Muted with a live sample: pin must stay silent.
    strobe(4096);
    ok = 1'b1;
    repeat (10000) begin
      step();
      if (dout !== 1'b0 || muted !== 1'b1) ok = 1'b0;
    end
    check("hold_silent", 32'(ok), 32'd1);

    // Unmute ramp.
    mute = 1'b0;
    step();
    check("unmute_muted_low", 32'(muted), 32'd0);
    check("unmute_state", 32'(dut.state_r), 32'(RAMP_UP));
    prev = int'(dut.gain_r); mono = 1'b1; spacing = 1'b1; reached = 1'b0;
    last_step = -1; cyc = 0;
    while (!reached && cyc < 1026) begin
      step();
      cyc++;
      g = int'(dut.gain_r);
      if (g < prev || g > prev + 1) mono = 1'b0;
      if (g == prev + 1) begin
        if (last_step >= 0 && cyc - last_step != 4) spacing = 1'b0;
        last_step = cyc;
      end
      prev = g;
      if (dut.state_r == PLAY) reached = 1'b1;
    end
    check("ramp_reached_play", 32'(reached), 32'd1);
    check("ramp_monotonic",    32'(mono),    32'd1);
    check("ramp_step_every_4", 32'(spacing), 32'd1);
    check("play_gain",         32'(dut.gain_r), 32'd256);

    // Density at unity gain.
    density(4096, n); check("density_4096", 32'(n), 32'd4096);
    density(0, n);    check("density_0",    32'(n), 32'd0);
    density(8191, n); check("density_8191", 32'(n), 32'd8191);

    // Strobe gating.
    density(2048, n); check("density_2048", 32'(n), 32'd2048);
    din = DW'(8000);
    count_ones(n);    check("gated_din_ignored", 32'(n), 32'd2048);
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    check("lvl_old_after_strobe", 32'(dut.lvl_r), 32'd2048);
    step();
    check("lvl_new_next_clock", 32'(dut.lvl_r), 32'd8000);
    step();
    count_ones(n);    check("density_8000", 32'(n), 32'd8000);

    // Ramp down to silence.
    mute = 1'b1;
    n = 0;
    while (muted !== 1'b1 && n < 1100) begin step(); n++; end
    check("ramp_down_muted", 32'(muted), 32'd1);

    // Reversal at g = 100 on the way up.
    mute = 1'b0;
    wait_gain("reach_g100", 100, 500);
    mute = 1'b1;
    step();
    check("rev_down_state", 32'(dut.state_r), 32'(RAMP_DOWN));
    check("rev_down_gain",  32'(dut.gain_r),  32'd100);
    cyc = 1;
    while (dut.gain_r != 0 && cyc < 410) begin step(); cyc++; end
    check("g0_muted_same_clock", 32'(muted), 32'd1);
    check("g0_state_muted", 32'(dut.state_r), 32'(MUTED));
    check("g0_after_100_ticks", 32'(cyc >= 397 && cyc <= 400), 32'd1);

    // Reversal at g = 50 on the way down.
    mute = 1'b0;
    wait_gain("reach_g80", 80, 400);
    mute = 1'b1;
    wait_gain("reach_g50", 50, 200);
    mute = 1'b0;
    step();
    check("rev_up_state", 32'(dut.state_r), 32'(RAMP_UP));
    check("rev_up_gain",  32'(dut.gain_r),  32'd50);

    // Half gain held by alternating reversals.
    strobe(8191);
    wait_gain("reach_g128", 128, 400);
    mute = 1'b1;
    repeat (3) hold_step();
    check("half_gain_lvl", 32'(dut.lvl_r), 32'd4095);
    n = 0;
    for (int i = 0; i < 8192; i++) begin
      hold_step();
      if (dout === 1'b1) n++;
    end
    check("density_half_gain", 32'(n), 32'd4095);
    check("half_gain_held", 32'(dut.gain_r), 32'd128);

    // Asynchronous reset between edges.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_dout",  32'(dout),  32'd0);
    check("async_rst_muted", 32'(muted), 32'd1);
    check("async_rst_gain",  32'(dut.gain_r), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
